cmd_dispatcher: RTL and testbench
=================================

Name: cmd_dispatcher

Overview:
- Upstream feeder of the scoreboard.
- Accepts incoming commands over a valid/ready handshake and allocates a free processor to each one.
- Writes the {cmd_id, proc_id} entry into the scoreboard and waits for its ack, then issues a one-hot start pulse to the allocated processor.
- Tracks processor occupancy in a busy mask; processors are released by their done pulses.

Parameters:
- CMD_W, 8, width of command id; must equal the width of the entry_t cmd_id field.
- PROC_COUNT, `PROC_COUNT (4), number of processors; proc id width is $clog2(PROC_COUNT).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_cmd_valid  in  1  upstream command valid
- i_cmd_id  in  CMD_W  upstream command id
- o_cmd_ready  out  1  dispatcher can accept a command this cycle
- o_sb_entry  out  entry_t  entry presented to scoreboard i_entry
- o_sb_write  out  1  scoreboard write strobe, one-cycle pulse
- i_sb_ack  in  1  scoreboard o_ack
- o_proc_start  out  PROC_COUNT  one-hot start pulse, one cycle
- o_proc_cmd_id  out  CMD_W  cmd id accompanying o_proc_start
- i_proc_done  in  PROC_COUNT  per-processor done pulses
- o_busy_mask  out  PROC_COUNT  processor occupancy
- o_full  out  1  all processors busy

Behaviour:
- Reset values (i_rst sampled high at a rising edge):
  - state=IDLE.
  - o_sb_write=0, o_proc_start=0, o_busy_mask=0, o_sb_entry=0, o_proc_cmd_id=0.
  - o_cmd_ready=0 during the reset cycle.
- Reset mid-operation: any latched command is dropped, no start is issued, and the busy mask clears.
- FSM states:
  - IDLE:
    - o_cmd_ready = !o_full.
    - On i_cmd_valid && o_cmd_ready, latch i_cmd_id and go to ALLOC.
  - ALLOC:
    - Select the free processor (see arbitration) and latch its index into o_sb_entry.proc_id, with cmd_id = latched id.
    - Go to SB_WRITE.
  - SB_WRITE:
    - o_sb_write=1 for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK:
    - Hold o_sb_entry stable.
    - On i_sb_ack go to ISSUE; there is no timeout.
    - An i_sb_ack seen in any other state is ignored.
  - ISSUE:
    - o_proc_start[proc]=1 and o_proc_cmd_id=latched id for one cycle.
    - busy[proc] is set at the end of this cycle; return to IDLE.
- Minimum latency from accept to start pulse: 4 cycles, given ack on the first WAIT_ACK cycle.
- Exactly one command is in flight; o_cmd_ready=0 in all states other than IDLE.
- Busy mask:
  - busy_next = (busy & ~i_proc_done) | set_mask.
  - A done on a non-busy bit is ignored.
  - A done and a set on different bits in the same cycle both take effect.
  - A done on the bit being set in ISSUE cannot occur legally; if it does, the set wins.
- o_full = &o_busy_mask, combinational from the registered mask.
- A free processor is guaranteed at ALLOC, because ready required !o_full and only this block sets busy bits.
- A done arriving between accept and ALLOC only enlarges the free set.
- Default arbitration: lowest-index free processor.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - ALLOC picks the first free processor at or after a rotating pointer.
  - The pointer advances to (granted index + 1) mod PROC_COUNT in ISSUE and resets to 0.
- Undefined:
  - Fixed lowest-index priority.
  - No pointer register exists.

Decomposition:
- Shared package (alongside the scoreboard):
  - entry_t {cmd_id, proc_id}.
  - `PROC_COUNT.
  - PROC_ID_W = $clog2(`PROC_COUNT).
  - dispatcher state enum disp_state_t.
- Sub-module proc_alloc:
  - Combinational free-mask to index encoder, with a grant-valid output.
  - Takes an optional rotate-pointer input under ARB_ROUND_ROBIN_EN.
- FSM and busy mask stay in cmd_dispatcher.

Test Plan:
- Reset, then cmd_id=5 valid with an ack stub replying 1 cycle after the write:
  - o_sb_entry={5,0} with o_sb_write pulse.
  - o_proc_start=4'b0001 and o_proc_cmd_id=5.
  - o_busy_mask=4'b0001.
- Issue ids 1,2,3,4 back-to-back with no dones:
  - Processors 0,1,2,3 allocated in order.
  - o_full=1 and o_cmd_ready=0; a fifth command (id 9) stalls.
  - i_proc_done=4'b0100 → id 9 is assigned proc 2.
- Ack delayed 6 cycles:
  - o_sb_write is high for exactly 1 cycle.
  - o_sb_entry is stable for all 6 cycles; o_proc_start fires the cycle after ack.
- Busy=4'b0011, done=4'b0001 in the same cycle as ISSUE to proc 2:
  - Next busy=4'b0110.
  - A spurious done on bit 3 leaves the mask unchanged.
- i_rst asserted in WAIT_ACK:
  - No start pulse; busy=0; state IDLE.
  - A subsequent cmd_id=7 is allocated proc 0.
- ARB_ROUND_ROBIN_EN defined, with each command followed by done before the next:
  - Commands 1,2,3 get processors 0,1,2, not 0,0,0.

Source files
------------

// File: rtl/cmd_dispatcher_pkg.sv
// Types shared by the command dispatcher and the scoreboard: entry layout,
// processor-count configuration and the dispatcher state encoding.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package cmd_dispatcher_pkg;

  localparam int CMD_ID_W  = 8;
  localparam int PROC_N    = `PROC_COUNT;
  localparam int PROC_ID_W = $clog2(`PROC_COUNT);

  typedef struct packed {
    logic [CMD_ID_W-1:0]  cmd_id;
    logic [PROC_ID_W-1:0] proc_id;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    ALLOC,
    SB_WRITE,
    WAIT_ACK,
    ISSUE
  } disp_state_t;

endpackage

// File: rtl/cmd_dispatcher_alloc.sv
// Free-processor encoder: lowest-index free processor, or the first free one at
// or after a rotating pointer when ARB_ROUND_ROBIN_EN is defined.
module proc_alloc
  import cmd_dispatcher_pkg::*;
#(
  parameter int PROC_COUNT = `PROC_COUNT
) (
  input  logic [PROC_COUNT-1:0] free_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [PROC_ID_W-1:0]  ptr_i,
`endif
  output logic [PROC_ID_W-1:0]  grant_idx_o,
  output logic                  grant_vld_o
);

  always_comb begin
    int j;
    j           = 0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int i = 0; i < PROC_COUNT; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      j = (int'(ptr_i) + i) % PROC_COUNT;
`else
      j = i;
`endif
      if (!grant_vld_o && free_i[j]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = PROC_ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: accepts one command at a time, allocates a free processor,
// registers it with the scoreboard and starts it. Optional: ARB_ROUND_ROBIN_EN.
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int CMD_W      = 8,
  parameter int PROC_COUNT = `PROC_COUNT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [CMD_W-1:0]      i_cmd_id,
  output logic                  o_cmd_ready,
  output entry_t                o_sb_entry,
  output logic                  o_sb_write,
  input  logic                  i_sb_ack,
  output logic [PROC_COUNT-1:0] o_proc_start,
  output logic [CMD_W-1:0]      o_proc_cmd_id,
  input  logic [PROC_COUNT-1:0] i_proc_done,
  output logic [PROC_COUNT-1:0] o_busy_mask,
  output logic                  o_full
);

  disp_state_t           state_q, state_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  entry_t                entry_q, entry_d;
  logic [PROC_COUNT-1:0] busy_q, busy_d, set_mask;
  logic [PROC_ID_W-1:0]  grant_idx;
  logic                  grant_vld;
`ifdef ARB_ROUND_ROBIN_EN
  logic [PROC_ID_W-1:0]  ptr_q, ptr_d;
`endif

  assign o_full      = &busy_q;
  assign o_busy_mask = busy_q;
  assign o_sb_entry  = entry_q;

  proc_alloc #(
    .PROC_COUNT (PROC_COUNT)
  ) u_alloc (
    .free_i      (~busy_q),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr_i       (ptr_q),
`endif
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    entry_d       = entry_q;
    set_mask      = '0;
    o_cmd_ready   = 1'b0;
    o_sb_write    = 1'b0;
    o_proc_start  = '0;
    o_proc_cmd_id = '0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d         = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        o_cmd_ready = !o_full && !i_rst;
        if (i_cmd_valid && o_cmd_ready) begin
          cmd_d   = i_cmd_id;
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        // A free processor is guaranteed here; the fallback only guards misuse.
        if (grant_vld) begin
          entry_d.cmd_id  = cmd_q;
          entry_d.proc_id = grant_idx;
          state_d         = SB_WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      SB_WRITE: begin
        o_sb_write = !i_rst;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_sb_ack) state_d = ISSUE;
      end
      ISSUE: begin
        set_mask      = PROC_COUNT'(1) << entry_q.proc_id;
        o_proc_start  = i_rst ? '0 : set_mask;
        o_proc_cmd_id = cmd_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d         = PROC_ID_W'((int'(entry_q.proc_id) + 1) % PROC_COUNT);
`endif
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Set after clear, so a set wins over a same-bit done.
    busy_d = (busy_q & ~i_proc_done) | set_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      entry_q <= '0;
      busy_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      entry_q <= entry_d;
      busy_q  <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Randomized and directed bench for cmd_dispatcher against a set-based model.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

module tb_cmd_dispatcher;
  import cmd_dispatcher_pkg::*;

  localparam int N  = `PROC_COUNT;
  localparam int PW = $clog2(`PROC_COUNT);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic [7:0]    i_cmd_id = '0;
  logic          o_cmd_ready;
  entry_t        o_sb_entry;
  logic          o_sb_write;
  logic          i_sb_ack = 1'b0;
  logic [N-1:0]  o_proc_start;
  logic [7:0]    o_proc_cmd_id;
  logic [N-1:0]  i_proc_done = '0;
  logic [N-1:0]  o_busy_mask;
  logic          o_full;

  int errors = 0;
  int checks = 0;

  // Reference model: set of busy processors and the round-robin pointer.
  bit mbusy[N];
  int mptr;

  always #5 i_clk = ~i_clk;

  cmd_dispatcher #(.CMD_W(8), .PROC_COUNT(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd_id(i_cmd_id),
    .o_cmd_ready(o_cmd_ready), .o_sb_entry(o_sb_entry), .o_sb_write(o_sb_write),
    .i_sb_ack(i_sb_ack), .o_proc_start(o_proc_start), .o_proc_cmd_id(o_proc_cmd_id),
    .i_proc_done(i_proc_done), .o_busy_mask(o_busy_mask), .o_full(o_full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < N; i++) if (mbusy[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      int j = (mptr + i) % N;
`else
      int j = i;
`endif
      if (!mbusy[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!mbusy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_busy", o_busy_mask, 0);
    chk("rst_write", o_sb_write, 0);
    chk("rst_start", o_proc_start, 0);
    chk("rst_entry", o_sb_entry, 0);
    chk("rst_pcmd", o_proc_cmd_id, 0);
    i_rst = 1'b0;
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    mptr = 0;
    #1;
    chk("post_rst_ready", o_cmd_ready, 1);
  endtask

  task automatic pulse_done(input logic [N-1:0] m);
    i_proc_done = m;
    step();
    i_proc_done = '0;
    for (int i = 0; i < N; i++) if (m[i]) mbusy[i] = 1'b0;
    chk("done_busy", o_busy_mask, model_mask());
    chk("done_full", o_full, model_full());
  endtask

  // One full transaction; returns the processor the DUT wrote into the entry.
  task automatic do_cmd(input logic [7:0] id, input int delay,
                        input logic [N-1:0] done_at_issue, output int got_p);
    int n = 0;
    int ep;
    logic [31:0] exp_entry;
    got_p = -1;
    while (!o_cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    ep = model_pick();
    exp_entry = (32'(id) << PW) | 32'(ep);
    i_cmd_valid = 1'b1;
    i_cmd_id    = id;
    step();
    i_cmd_valid = 1'b0;
    chk("alloc_ready", o_cmd_ready, 0);
    chk("alloc_write", o_sb_write, 0);
    step();
    chk("sb_write", o_sb_write, 1);
    chk("sb_entry", o_sb_entry, exp_entry);
    got_p = int'(o_sb_entry.proc_id);
    step();
    for (int k = 1; k <= delay; k++) begin
      chk("wait_write", o_sb_write, 0);
      chk("wait_entry", o_sb_entry, exp_entry);
      chk("wait_start", o_proc_start, 0);
      i_sb_ack = (k == delay);
      step();
    end
    i_sb_ack = 1'b0;
    chk("start", o_proc_start, 32'(1) << ep);
    chk("start_cmd", o_proc_cmd_id, id);
    i_proc_done = done_at_issue;
    step();
    i_proc_done = '0;
    for (int i = 0; i < N; i++) if (done_at_issue[i]) mbusy[i] = 1'b0;
    mbusy[ep] = 1'b1;
    mptr = (ep + 1) % N;
    chk("start_gone", o_proc_start, 0);
    chk("issue_busy", o_busy_mask, model_mask());
    chk("issue_full", o_full, model_full());
  endtask

  initial begin
    int p;
    logic [N-1:0] rm;
    i_rst = 1'b1;
    step();
    do_reset();

    // Single command, ack one cycle after the write.
    do_cmd(8'd5, 1, '0, p);
    chk("t1_proc", p, 0);
    chk("t1_busy", o_busy_mask, 32'b0001);
    pulse_done(4'b0001);

    // Fill every processor, then stall a fifth command.
    for (int i = 1; i <= 4; i++) begin
      do_cmd(8'(i), 1, '0, p);
      chk("fill_proc", p, i - 1);
    end
    chk("full", o_full, 1);
    i_cmd_valid = 1'b1;
    i_cmd_id    = 8'd9;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", o_cmd_ready, 0);
      chk("stall_write", o_sb_write, 0);
      step();
    end
    i_cmd_valid = 1'b0;
    pulse_done(4'b0100);
    do_cmd(8'd9, 1, '0, p);
    chk("id9_proc", p, 2);
    pulse_done(4'b1111);

    // Slow ack.
    do_cmd(8'h33, 6, '0, p);
    pulse_done(4'b1111);

    // Done and set in the same cycle, then a spurious done.
    do_reset();
    do_cmd(8'h10, 1, '0, p);
    do_cmd(8'h11, 1, '0, p);
    chk("pre_busy", o_busy_mask, 32'b0011);
    do_cmd(8'h12, 1, 4'b0001, p);
    chk("same_cyc_proc", p, 2);
    chk("same_cyc_busy", o_busy_mask, 32'b0110);
    pulse_done(4'b1000);
    chk("spurious_busy", o_busy_mask, 32'b0110);

    // Reset while waiting for the ack; a stray ack in IDLE is ignored.
    i_cmd_valid = 1'b1;
    i_cmd_id    = 8'h44;
    step();
    i_cmd_valid = 1'b0;
    step();
    step();
    i_rst = 1'b1;
    chk("rst_wait_start", o_proc_start, 0);
    step();
    chk("rst_wait_start2", o_proc_start, 0);
    do_reset();
    i_sb_ack = 1'b1;
    step();
    i_sb_ack = 1'b0;
    chk("stray_ack_start", o_proc_start, 0);
    chk("stray_ack_write", o_sb_write, 0);
    do_cmd(8'd7, 1, '0, p);
    chk("after_rst_proc", p, 0);

    // Sequential commands each released before the next.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      do_cmd(8'(i), 1, '0, p);
`ifdef ARB_ROUND_ROBIN_EN
      chk("seq_proc", p, i - 1);
`else
      chk("seq_proc", p, 0);
`endif
      pulse_done(N'(1) << p);
    end

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      rm = N'($urandom);
      if ($urandom_range(0, 2) == 0) pulse_done(rm);
      while (model_full()) pulse_done(N'(1) << $urandom_range(0, N - 1));
      rm = N'($urandom) & N'(model_mask());
      do_cmd(8'($urandom), $urandom_range(1, 5), rm, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
